// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_pkg;

  // Sequencer states: IDLE accepts a request, READ walks the four byte
  // lanes, HOLD presents the assembled word until the core takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/fetch_sequencer.sv
// Assembles a 32-bit little-endian instruction from a byte-wide memory, one byte per cycle.
// Latency: request accepted at edge N, instrValid high after edge N+4 (N+1 for a misalign trap).
// Backpressure: fetchReady low while busy; the word is held in HOLD until instrAck (flush aborts).
//
// Ports:
//   clk, resetN             clock, async active-low reset
//   fetchReq/fetchAddr      request in, accepted when fetchReady=1 and flush=0
//   fetchReady              high only in IDLE
//   memAddr/memData         byte address out, byte returned combinationally
//   flush                   abort any fetch in progress (READ or HOLD)
//   instruction/instrValid  assembled word, valid held until instrAck
//   misalignErr             trap flag, qualified by instrValid
//   fetchCount              acknowledged fetches, wraps at 2^CNT_W
//
// Build option: define IMEM_MISALIGN_TRAP_EN to trap requests whose fetchAddr[1:0] != 0
// instead of reading them byte by byte.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchReady,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [7:0]        memData,
  input  logic              flush,
  output logic [31:0]       instruction,
  output logic              instrValid,
  input  logic              instrAck,
  output logic              misalignErr,
  output logic [CNT_W-1:0]  fetchCount
);

  state_t              state;
  state_t              nextState;
  logic [ADDR_W-1:0]   base;
  logic [LANE_W-1:0]   byteCnt;

  logic                accept;       // request taken this cycle
  logic                capture;      // write memData into lane byteCnt
  logic                retire;       // instrAck honoured in HOLD
  logic                holdExit;     // leaving HOLD by ack or flush
  logic                misalignedReq;

`ifdef IMEM_MISALIGN_TRAP_EN
  assign misalignedReq = |fetchAddr[LANE_W-1:0];
`else
  assign misalignedReq = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state and datapath strobes. flush outranks instrAck and fetchReq.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    holdExit  = 1'b0;
    case (state)
      IDLE: begin
        if (fetchReq && !flush) begin
          accept    = 1'b1;
          nextState = misalignedReq ? HOLD : READ;
        end
      end
      READ: begin
        if (flush) begin
          nextState = IDLE;
        end else begin
          capture = 1'b1;
          if (byteCnt == LANE_W'(BYTES_PER_WORD - 1)) begin
            nextState = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          nextState = IDLE;
          holdExit  = 1'b1;
        end else if (instrAck) begin
          nextState = IDLE;
          retire    = 1'b1;
          holdExit  = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath. A flushed READ leaves already-written lanes in place and the
  // remaining lanes at their previous contents.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      base        <= '0;
      byteCnt     <= '0;
      instruction <= '0;
      fetchCount  <= '0;
    end else begin
      if (accept) begin
        base    <= fetchAddr;
        byteCnt <= '0;
        if (misalignedReq) begin
          instruction <= '0;
        end
      end
      if (capture) begin
        instruction[{byteCnt, 3'b000} +: 8] <= memData;
        // Wraps back to 0 after lane 3, ready for the next word.
        byteCnt <= byteCnt + LANE_W'(1);
      end
      if (retire) begin
        fetchCount <= fetchCount + CNT_W'(1);
      end
    end
  end

`ifdef IMEM_MISALIGN_TRAP_EN
  logic misalignQ;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      misalignQ <= 1'b0;
    end else if (accept) begin
      misalignQ <= misalignedReq;
    end else if (holdExit) begin
      misalignQ <= 1'b0;
    end
  end

  assign misalignErr = misalignQ;
`else
  assign misalignErr = 1'b0;
`endif

  assign fetchReady = (state == IDLE);
  assign instrValid = (state == HOLD);
  // Address adder wraps naturally at 2^ADDR_W.
  assign memAddr    = (state == READ) ? (base + ADDR_W'(byteCnt)) : '0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer using a byte memory model and an expected-word queue.
// Latency: checks the N+4 (or N+1 trap) valid timing and the per-cycle memAddr walk.
// Backpressure: exercises withheld ack, flush in READ/HOLD/IDLE and async reset mid-fetch.
module tb_fetch_sequencer;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              resetN;
  logic              fetchReq;
  logic [ADDR_W-1:0] fetchAddr;
  logic              fetchReady;
  logic [ADDR_W-1:0] memAddr;
  logic [7:0]        memData;
  logic              flush;
  logic [31:0]       instruction;
  logic              instrValid;
  logic              instrAck;
  logic              misalignErr;
  logic [CNT_W-1:0]  fetchCount;

  logic [7:0] mem [0:255];
  assign memData = mem[memAddr];

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .fetchReq    (fetchReq),
    .fetchAddr   (fetchAddr),
    .fetchReady  (fetchReady),
    .memAddr     (memAddr),
    .memData     (memData),
    .flush       (flush),
    .instruction (instruction),
    .instrValid  (instrValid),
    .instrAck    (instrAck),
    .misalignErr (misalignErr),
    .fetchCount  (fetchCount)
  );

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];        // {misalign, instruction}
  logic [31:0] model_instr;     // last word the DUT should be showing
  logic [CNT_W-1:0] model_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [31:0] w;
    logic [7:0]  p;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      p = a + 8'(i);
      w[i*8 +: 8] = mem[p];
    end
    return w;
  endfunction

  function automatic bit is_trap(input logic [7:0] a);
`ifdef IMEM_MISALIGN_TRAP_EN
    return (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Returns at the negedge following the accepting edge N.
  task automatic start_fetch(input logic [7:0] a);
    @(negedge clk);
    chk("ready_before_req", 32'(fetchReady), 32'd1);
    fetchReq  = 1'b1;
    fetchAddr = a;
    @(negedge clk);
    fetchReq  = 1'b0;
    fetchAddr = 8'($urandom);
  endtask

  task automatic sb_pop();
    int n;
    logic [32:0] e;
    n = 0;
    while (!instrValid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!instrValid) begin
      chk("valid_timeout", 32'(instrValid), 32'd1);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      chk("instr", instruction, e[31:0]);
      chk("misalign", 32'(misalignErr), 32'(e[32]));
      model_instr = e[31:0];
    end
  endtask

  task automatic run_fetch(input logic [7:0] a);
    bit t;
    t = is_trap(a);
    start_fetch(a);
    if (t) exp_q.push_back({1'b1, 32'h0});
    else   exp_q.push_back({1'b0, word_at(a)});
    if (!t) begin
      for (int i = 0; i < 4; i++) begin
        chk("memaddr", 32'(memAddr), 32'(8'(a + 8'(i))));
        chk("early_valid", 32'(instrValid), 32'd0);
        @(negedge clk);
      end
    end
    chk("valid_latency", 32'(instrValid), 32'd1);
    sb_pop();
  endtask

  task automatic ack_fetch();
    instrAck = 1'b1;
    @(negedge clk);
    instrAck = 1'b0;
    model_count = model_count + CNT_W'(1);
    chk("ack_ready", 32'(fetchReady), 32'd1);
    chk("ack_valid", 32'(instrValid), 32'd0);
    chk("ack_count", 32'(fetchCount), 32'(model_count));
    chk("ack_misalign", 32'(misalignErr), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(fetchReady), 32'd1);
    chk({tag, "_valid"}, 32'(instrValid), 32'd0);
    chk({tag, "_instr"}, instruction, 32'd0);
    chk({tag, "_count"}, 32'(fetchCount), 32'd0);
    chk({tag, "_memaddr"}, 32'(memAddr), 32'd0);
    chk({tag, "_misalign"}, 32'(misalignErr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h02; mem[1] = 8'h00; mem[2] = 8'h08; mem[3] = 8'h21;
    resetN = 1'b0; fetchReq = 1'b0; fetchAddr = '0; flush = 1'b0; instrAck = 1'b0;
    model_instr = '0; model_count = '0;

    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    resetN = 1'b1;

    // Aligned fetch from 0, then hold without ack for five cycles.
    run_fetch(8'h00);
    chk("word0_const", model_instr, 32'h21080002);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(instrValid), 32'd1);
      chk("hold_instr", instruction, 32'h21080002);
      chk("hold_count", 32'(fetchCount), 32'd0);
    end
    ack_fetch();

    // Address wrap from 0xFE.
    run_fetch(8'hFE);
    ack_fetch();

    // flush in IDLE blocks a simultaneous request.
    @(negedge clk);
    fetchReq = 1'b1; fetchAddr = 8'h40; flush = 1'b1;
    @(negedge clk);
    fetchReq = 1'b0; flush = 1'b0;
    chk("idle_flush_ready", 32'(fetchReady), 32'd1);
    chk("idle_flush_memaddr", 32'(memAddr), 32'd0);

    // flush in the second READ cycle: only lane 0 was rewritten.
    start_fetch(8'h10);
    chk("flushrd_valid0", 32'(instrValid), 32'd0);
    @(negedge clk);
    chk("flushrd_memaddr", 32'(memAddr), 32'h11);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_instr = {model_instr[31:8], mem[8'h10]};
    chk("flushrd_ready", 32'(fetchReady), 32'd1);
    chk("flushrd_valid", 32'(instrValid), 32'd0);
    chk("flushrd_count", 32'(fetchCount), 32'(model_count));
    chk("flushrd_instr", instruction, model_instr);

    // flush together with ack in HOLD: no count.
    run_fetch(8'h20);
    flush = 1'b1; instrAck = 1'b1;
    @(negedge clk);
    flush = 1'b0; instrAck = 1'b0;
    chk("flushhold_ready", 32'(fetchReady), 32'd1);
    chk("flushhold_valid", 32'(instrValid), 32'd0);
    chk("flushhold_count", 32'(fetchCount), 32'(model_count));
    chk("flushhold_instr", instruction, model_instr);

    // Asynchronous reset in the middle of READ.
    start_fetch(8'h30);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_count = '0;
    model_instr = '0;
    @(negedge clk);
    resetN = 1'b1;
    run_fetch(8'h30);
    ack_fetch();

    // Misaligned request: trap with the option, ordinary read without.
    run_fetch(8'h05);
    ack_fetch();

    // A few random addresses.
    for (int k = 0; k < 6; k++) begin
      run_fetch(8'($urandom));
      ack_fetch();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address width of the instruction memory.
REQ-002 SHALL have parameter CNT_W, default 16, width of the completed-fetch counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port resetN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fetchReq  input  1  core requests one instruction fetch.
REQ-006 SHALL have port fetchAddr  input  ADDR_W  byte address of the requested instruction.
REQ-007 SHALL have port fetchReady  output  1  sequencer idle; a request is accepted this cycle.
REQ-008 SHALL have port memAddr  output  ADDR_W  byte address driven to the byte-wide instruction memory.
REQ-009 SHALL have port memData  input  8  byte returned combinationally by memory for memAddr.
REQ-010 SHALL have port flush  input  1  abort any fetch in progress.
REQ-011 SHALL have port instruction  output  32  assembled little-endian instruction word.
REQ-012 SHALL have port instrValid  output  1  instruction is valid; held until acknowledged.
REQ-013 SHALL have port instrAck  input  1  core consumes instruction.
REQ-014 SHALL have port misalignErr  output  1  misaligned-request flag, qualified by instrValid.
REQ-015 SHALL have port fetchCount  output  CNT_W  number of acknowledged fetches.

Function
REQ-016 SHALL implement states IDLE, READ, HOLD; fetchReady=1 only in IDLE.
REQ-017 SHALL accept a request in IDLE when fetchReq=1 and flush=0: latch base=fetchAddr, byteCnt=0, go to READ.
REQ-018 SHALL in READ drive memAddr=base+byteCnt, modulo 2^ADDR_W (wrap from max address to 0), and capture memData into instruction byte lane byteCnt at each edge.
REQ-019 SHALL in READ increment byteCnt each cycle and go to HOLD after lane 3 is captured: request accepted at edge N, instrValid=1 after edge N+4.
REQ-020 SHALL drive memAddr=0 in IDLE and HOLD.
REQ-021 SHALL hold instrValid=1 and instruction stable in HOLD until instrAck=1, then go to IDLE and increment fetchCount (wraps modulo 2^CNT_W).
REQ-022 SHALL, on flush=1 in READ or HOLD, go to IDLE at the next edge, drop instrValid, not increment fetchCount; flush has priority over instrAck and fetchReq.
REQ-023 SHALL ignore flush in IDLE except that it blocks acceptance of a simultaneous request.
REQ-024 SHALL ignore instrAck outside HOLD and fetchReq outside IDLE.
REQ-025 SHALL leave instruction unchanged on flush; lanes not yet rewritten keep prior values.

Reset
REQ-026 SHALL on resetN=0, immediately and regardless of state, enter IDLE with instruction=0, instrValid=0, misalignErr=0, fetchCount=0, byteCnt=0, base=0, memAddr=0.
REQ-027 SHALL discard any in-progress fetch on reset; fetchReady=1 from reset deassertion.

Configuration
REQ-028 SHALL with IMEM_MISALIGN_TRAP_EN defined, on accepting a request with fetchAddr[1:0]!=0, go directly to HOLD next edge with instruction=0, misalignErr=1, instrValid=1, no memory reads; misalignErr cleared on ack, flush or reset; acked traps counted in fetchCount.
REQ-029 SHALL without IMEM_MISALIGN_TRAP_EN, tie misalignErr to 0 and fetch misaligned addresses normally per REQ-018.

Structure
REQ-030 SHALL place the state enum, BYTES_PER_WORD=4 and byte-lane index width in shared package fetch_pkg.
REQ-031 SHALL be a single module; no sub-module.

Verification
REQ-032 SHALL cover: mem[0..3]=02,00,08,21, fetchAddr=0 -> memAddr 0,1,2,3 over 4 cycles, instruction=0x21080002 with instrValid after edge N+4.
REQ-033 SHALL cover: ack withheld 5 cycles -> instrValid and instruction stable; ack -> IDLE next edge, fetchCount 0->1.
REQ-034 SHALL cover: ADDR_W=8, fetchAddr=0xFE -> memAddr 0xFE,0xFF,0x00,0x01.
REQ-035 SHALL cover: flush in second READ cycle -> IDLE next edge, instrValid never 1, fetchCount unchanged; flush+instrAck in HOLD -> no count.
REQ-036 SHALL cover: resetN low mid-READ -> all outputs at reset values asynchronously; new fetch after release completes normally.
REQ-037 SHALL cover: fetchAddr=0x05 -> with macro misalignErr=1, instruction=0 one edge after accept; without macro normal 4-byte read from 0x05.
